// File: rtl/spi_byte_if_if.sv
// SPI slave pins plus the parallel byte handshake for spi_byte_if.
// The slave modport is the byte interface's own view; master is the SPI master plus message layer.
interface spi_byte_if_if;
  logic       SCLK;
  logic       SS;
  logic       MOSI;
  logic       MISO;
  logic       misoOe;
  logic       rxValid;
  logic [7:0] rx;
  logic [7:0] tx;

  modport slave (
    input  SCLK, SS, MOSI, tx,
    output MISO, misoOe, rxValid, rx
  );

  modport master (
    output SCLK, SS, MOSI, tx,
    input  MISO, misoOe, rxValid, rx
  );
endinterface

// File: rtl/spi_byte_if.sv
// SPI mode-0 byte slave, MSB first, oversampled on sysClk.
// Receives bytes on MOSI into rx and shifts tx out on MISO.
module spi_byte_if (
  input  logic         sysClk,
  input  logic         usrReset,
  spi_byte_if_if.slave spi
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t     state_q, state_d;

  // Bit 0 is the metastability flop, bit 1 the synchronized value, bit 2 its previous value.
  logic [2:0] sclk_sync;
  logic [2:0] ss_sync;
  logic [1:0] mosi_sync;

  logic       sclk_rise, sclk_fall;
  logic       ss_rise, ss_fall;
  logic       mosi_bit;

  logic       start_frame, stop_frame, shift_in, shift_out;

  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] rx_q;
  logic       rx_valid_q;
  logic [7:0] rx_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sysClk or posedge usrReset) begin
    if (usrReset) begin
      sclk_sync <= 3'b000;
      ss_sync   <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi.SCLK};
      ss_sync   <= {ss_sync[1:0], spi.SS};
      mosi_sync <= {mosi_sync[0], spi.MOSI};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign ss_rise   = ss_sync[1] & ~ss_sync[2];
  assign ss_fall   = ~ss_sync[1] & ss_sync[2];
  assign mosi_bit  = mosi_sync[1];

  always_ff @(posedge sysClk or posedge usrReset) begin
    if (usrReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    stop_frame  = 1'b0;
    shift_in    = 1'b0;
    shift_out   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d     = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        // Deselect wins over a coincident SCLK edge.
        if (ss_rise) begin
          state_d    = IDLE;
          stop_frame = 1'b1;
        end else begin
          shift_in  = sclk_rise;
          shift_out = sclk_fall;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_next = {rx_shift[6:0], mosi_bit};

  // NOTE: the shift registers are plain flops, not a memory array, so all of them reset cleanly.
  always_ff @(posedge sysClk or posedge usrReset) begin
    if (usrReset) begin
      bit_cnt    <= 3'd0;
      rx_shift   <= 8'h00;
      tx_shift   <= 8'h00;
      rx_q       <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (start_frame) begin
        bit_cnt  <= 3'd0;
        tx_shift <= spi.tx;
      end else if (stop_frame) begin
        // A partial byte is dropped; clearing tx_shift keeps MISO low while idle.
        bit_cnt  <= 3'd0;
        rx_shift <= 8'h00;
        tx_shift <= 8'h00;
      end else if (shift_in) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_q       <= rx_next;
          rx_valid_q <= 1'b1;
        end
      end else if (shift_out) begin
        // bit_cnt wraps to 0 after the eighth rise, so the falling edge that follows starts the next byte.
        if (bit_cnt == 3'd0) begin
          tx_shift <= spi.tx;
        end else begin
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

  assign spi.MISO    = tx_shift[7];
  assign spi.misoOe  = (state_q == ACTIVE);
  assign spi.rxValid = rx_valid_q;
  assign spi.rx      = rx_q;

endmodule

// File: tb/tb_spi_byte_if.sv
// Directed bench for spi_byte_if: a bit-banged SPI master plus an rx scoreboard
// that is checked whenever rxValid pulses.
module tb_spi_byte_if;

  logic sysClk;
  logic usrReset;

  spi_byte_if_if intf ();

  spi_byte_if dut (
    .sysClk   (sysClk),
    .usrReset (usrReset),
    .spi      (intf)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  int         checks      = 0;
  int         failures    = 0;
  int         valid_count = 0;
  logic       prev_valid  = 1'b0;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every rxValid pulse pops one expected byte.
  always @(negedge sysClk) begin
    if (intf.rxValid === 1'b1) begin
      valid_count++;
      check("rxvalid_single_cycle", {31'd0, prev_valid}, 32'd0);
      check("rx_expected_pending", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        check("rx_byte", {24'd0, intf.rx}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_valid = intf.rxValid;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge sysClk);
  endtask

  // Mode-0 master: MOSI changes with SCLK low, MISO sampled at the rising edge.
  task automatic spi_xfer(input logic [7:0] mo, input int nbits, input int half,
                          output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      intf.MOSI = mo[i];
      cycles(half);
      intf.SCLK = 1'b1;
      mi[i] = intf.MISO;
      cycles(half);
      intf.SCLK = 1'b0;
    end
  endtask

  task automatic ss_low();
    intf.SS = 1'b0;
    cycles(8);
  endtask

  task automatic ss_high();
    cycles(8);
    intf.SS = 1'b1;
    cycles(8);
  endtask

  task automatic wait_valid(input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge sysClk);
      got = intf.rxValid;
    end
    check("rxvalid_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic check_idle_pins(input string tag);
    check({tag, "_misoOe"}, {31'd0, intf.misoOe}, 32'd0);
    check({tag, "_MISO"}, {31'd0, intf.MISO}, 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mi;
    logic [7:0] rx_bytes [3];
    logic [7:0] tx_plan  [2];
    logic [7:0] mo;
    int         base;

    intf.SCLK = 1'b0;
    intf.SS   = 1'b1;
    intf.MOSI = 1'b0;
    intf.tx   = 8'h00;
    usrReset  = 1'b1;
    cycles(4);

    check_idle_pins("reset");
    check("reset_rxValid", {31'd0, intf.rxValid}, 32'd0);
    check("reset_rx", {24'd0, intf.rx}, 32'h00);
    usrReset = 1'b0;
    cycles(4);
    check_idle_pins("after_reset");

    // Single byte at sysClk/16.
    intf.tx = 8'hA5;
    base = valid_count;
    ss_low();
    check("select_misoOe", {31'd0, intf.misoOe}, 32'd1);
    exp_q.push_back(8'h3C);
    spi_xfer(8'h3C, 8, 8, mi);
    check("single_miso", {24'd0, mi}, 32'hA5);
    ss_high();
    check("single_rx", {24'd0, intf.rx}, 32'h3C);
    check("single_valid_count", valid_count - base, 1);
    check_idle_pins("single_deselect");

    // Three back-to-back bytes; the message layer updates tx after each rxValid.
    rx_bytes = '{8'h00, 8'hFF, 8'h81};
    tx_plan  = '{8'h11, 8'h22};
    base = valid_count;
    ss_low();
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          exp_q.push_back(rx_bytes[k]);
          spi_xfer(rx_bytes[k], 8, 8, mi);
          check($sformatf("b2b_miso%0d", k), {24'd0, mi},
                k == 0 ? 32'hA5 : {24'd0, tx_plan[k-1]});
        end
      end
      begin
        for (int k = 0; k < 2; k++) begin
          wait_valid(400);
          @(negedge sysClk);
          intf.tx = tx_plan[k];
        end
      end
    join
    ss_high();
    check("b2b_valid_count", valid_count - base, 3);
    check("b2b_rx_last", {24'd0, intf.rx}, 32'h81);

    // Frame aborted after five bits, then a full byte.
    base = valid_count;
    ss_low();
    spi_xfer(8'hF0, 5, 8, mi);
    ss_high();
    check("abort_valid_count", valid_count - base, 0);
    check("abort_rx_held", {24'd0, intf.rx}, 32'h81);
    ss_low();
    exp_q.push_back(8'h5A);
    spi_xfer(8'h5A, 8, 8, mi);
    ss_high();
    check("after_abort_rx", {24'd0, intf.rx}, 32'h5A);
    check("after_abort_valid_count", valid_count - base, 1);

    // Reset mid-byte, then a fresh frame.
    base = valid_count;
    ss_low();
    spi_xfer(8'hAA, 3, 8, mi);
    usrReset = 1'b1;
    cycles(3);
    check_idle_pins("midreset");
    check("midreset_rx", {24'd0, intf.rx}, 32'h00);
    check("midreset_rxValid", {31'd0, intf.rxValid}, 32'd0);
    intf.SS = 1'b1;
    cycles(3);
    usrReset = 1'b0;
    cycles(10);
    check("midreset_valid_count", valid_count - base, 0);
    check_idle_pins("post_reset");
    intf.tx = 8'h3E;
    ss_low();
    exp_q.push_back(8'hC3);
    spi_xfer(8'hC3, 8, 8, mi);
    check("post_reset_miso", {24'd0, mi}, 32'h3E);
    ss_high();
    check("post_reset_rx", {24'd0, intf.rx}, 32'hC3);
    check("post_reset_valid_count", valid_count - base, 1);

    // SCLK activity while deselected is ignored.
    base = valid_count;
    for (int t = 0; t < 16; t++) begin
      intf.MOSI = 1'($urandom_range(0, 1));
      intf.SCLK = ~intf.SCLK;
      cycles(6);
      check_idle_pins($sformatf("deselected_toggle%0d", t));
    end
    check("deselected_valid_count", valid_count - base, 0);
    check("deselected_rx_held", {24'd0, intf.rx}, 32'hC3);

    // Minimum legal SCLK period (12 sysClk), back to back.
    intf.tx = 8'h96;
    base = valid_count;
    ss_low();
    for (int k = 0; k < 6; k++) begin
      mo = 8'($urandom_range(0, 255));
      exp_q.push_back(mo);
      spi_xfer(mo, 8, 6, mi);
      check($sformatf("fast_miso%0d", k), {24'd0, mi}, 32'h96);
    end
    ss_high();
    check("fast_valid_count", valid_count - base, 6);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
